lcd_stream_sequencer: RTL
=========================

# lcd_stream_sequencer

Sits between the UART receiver and the HD44780 bus writer of the 16x2 LCD path. It buffers received bytes and turns them into LCD write transactions. It tracks the cursor on the 2x16 panel and inserts address commands at line wrap. It also maps control characters to clear, newline and full re-initialisation. It owns the decision of *what* goes to the panel and *when*; the downstream writer owns E/RS/RW pin timing.

## Interface
Parameters:
- FIFO_DEPTH, 4: input byte buffer depth; power of two, >= 2.
- COLS, 16: visible columns per row.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous, active-high reset.
- RxD_data_ready  in  1  UART byte-valid level; may stay high for many cycles; one byte per rising edge.
- RxD_data  in  8  UART byte, stable while RxD_data_ready high.
- RDY  out  1  high when the FIFO can accept a byte.
- overflow  out  1  sticky; set when a byte edge arrives with the FIFO full.
- init_req  out  1  one-cycle pulse requesting the LCD power-on init sequence from the writer.
- init_done  in  1  one-cycle pulse from the writer when init completes.
- wr_valid  out  1  write request to the writer.
- wr_rs  out  1  0 = command, 1 = character data.
- wr_data  out  8  byte to write.
- wr_done  in  1  one-cycle pulse from the writer when the current write is finished.
- cur_row  out  1  current cursor row.
- cur_col  out  4  current cursor column, 0..COLS-1.

## Operation
- **Edge detect:** `prev` register holds RxD_data_ready and resets to 1, so a level that is high at reset release is not a byte. A rising edge with FIFO not full pushes RxD_data. A rising edge with FIFO full drops the byte and sets overflow.
- **FSM states:** INIT_WAIT, IDLE, DECODE, ISSUE, WAIT_DONE.
- **INIT_WAIT:** init_req pulses for one cycle on entry. The FSM waits for init_done, then clears the cursor to (0,0) and goes to IDLE. The FIFO keeps accepting bytes during INIT_WAIT.
- **IDLE:** if the FIFO is not empty, pop into `cur_byte` and go to DECODE.
- **DECODE:** classify `cur_byte`.
  - 0x20..0x7E: data write (rs=1, data = byte).
  - 0x0C: command 0x01 (clear); cursor goes to (0,0) after done.
  - 0x0A: command 0x80 | addr(next row, col 0); row toggles, col = 0.
  - 0x0D: flush the FIFO; cursor goes to (0,0); go to INIT_WAIT, which re-emits init_req.
  - Any other byte: discard and return to IDLE.
- **ISSUE / WAIT_DONE:** wr_valid=1; wr_rs and wr_data stay stable until a wr_done pulse is seen. Then wr_valid drops and the cursor updates.
- **Wrap:** after a data write at col == COLS-1, set col=0 and toggle row (row 1 wraps to row 0). Then issue command 0x80 | addr before returning to IDLE. The second write is a full handshake.
- **DDRAM address:** row 0 = 0x00 + col; row 1 = 0x40 + col. The column counter is 4 bits, and col never exceeds COLS-1.
- **Ignored inputs:** wr_done while wr_valid=0 is ignored. init_done outside INIT_WAIT is ignored.
- **RDY** = !full, registered from the occupancy count.
- **Simultaneous push and pop:**
  - With the FIFO not full, both occur and the count is unchanged.
  - With the FIFO full, the push is rejected even if a pop occurs in the same cycle.

## Timing
- **Reset values** (all outputs 0 during reset): RDY=0, overflow=0, init_req=0, wr_valid=0, wr_rs=0, wr_data=0x00, cur_row=0, cur_col=0. FIFO empty.
- **After reset release:**
  - First cycle: state INIT_WAIT, init_req=1, RDY=1.
  - Second cycle: init_req=0.
- **Edge to FIFO:** the byte is counted on the first edge where `prev`=0 and input=1. RDY reflects full one cycle after the push.
- **FIFO to bus:** IDLE pop at cycle N, DECODE at N+1, wr_valid=1 at N+2.
- **Handshake:**
  - If wr_done=1 at edge M, wr_valid=0 and the cursor updates at M+1.
  - The next IDLE pop happens at M+1 at the earliest.
  - For a wrap, the address command wr_valid=1 at M+2.
- **Reset mid-handshake:** wr_valid drops at the next edge. The writer shares rst and must abort.

## Test plan
- **Reset and init:** release rst; init_req pulses exactly one cycle after release. With RxD_data_ready held high across release, no byte is queued. Pulse init_done; the FSM reaches IDLE with cursor (0,0).
- **Characters:** send 0x33, 0x23, 0x56 with a 10-cycle ready pulse each.
  - Expect three data writes (rs=1) of 0x33, 0x23, 0x56, each held until wr_done.
  - Cursor ends at (0,3).
- **Wrap:** send 16 × 0x41, then 0x42.
  - The 16th data write is followed by command 0xC0.
  - 0x42 is then written with cursor ending at (1,1).
  - After 32 chars the wrap command is 0x80.
- **Control characters:**
  - 0x0A at (0,5) gives command 0xC0 and cursor (1,0).
  - 0x0C gives command 0x01 and cursor (0,0).
  - 0x07 produces no write.
- **CR re-init:** queue 0x41, 0x0D, 0x42 while the writer stalls. After the 0x41 write completes and 0x0D is decoded:
  - the FIFO empties;
  - init_req pulses;
  - no 0x42 write occurs.
- **Overflow:** stall wr_done and send FIFO_DEPTH+2 bytes.
  - RDY=0 once full; overflow=1 and stays set.
  - Exactly the first byte (on the bus) plus FIFO_DEPTH buffered bytes are written after the stall releases.

Source files
------------

// File: rtl/lcd_stream_sequencer.sv
// rtl/lcd_stream_sequencer.sv - UART byte buffer and HD44780 write sequencer for a 2x16 LCD
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   RxD_data_ready, RxD_data UART byte-valid level and byte (one byte per rising edge)
//   RDY, overflow            FIFO not full (registered), sticky dropped-byte flag
//   init_req, init_done      one-cycle init request to the bus writer and its completion pulse
//   wr_valid, wr_rs, wr_data write request to the bus writer (rs: 0 command, 1 data)
//   wr_done                  one-cycle completion pulse for the current write
//   cur_row, cur_col         tracked cursor position on the panel
module lcd_stream_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int COLS       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD_data_ready,
    input  logic [7:0] RxD_data,
    output logic       RDY,
    output logic       overflow,
    output logic       init_req,
    input  logic       init_done,
    output logic       wr_valid,
    output logic       wr_rs,
    output logic [7:0] wr_data,
    input  logic       wr_done,
    output logic       cur_row,
    output logic [3:0] cur_col
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [3:0]    LAST_COL = 4'(COLS - 1);

    typedef enum logic [2:0] {
        INIT_WAIT,
        IDLE,
        DECODE,
        ISSUE,
        WAIT_DONE
    } state_t;

    // Cursor effect applied once the outstanding write completes.
    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_CHAR,
        ACT_HOME,
        ACT_NEWLINE
    } act_t;

    state_t        state;
    act_t          act;
    logic          init_entry;
    logic [7:0]    cur_byte;

    logic          prev;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          byte_edge;
    logic          full;
    logic          push;
    logic          pop;
    logic          flush;

    // Set DDRAM address command: row 0 starts at 0x00, row 1 at 0x40.
    function automatic logic [7:0] ddram_cmd(input logic row, input logic [3:0] col);
        return {1'b1, row, 2'b00, col};
    endfunction

    // ------------------------------------------------------------------
    // Input byte FIFO
    // ------------------------------------------------------------------
    assign byte_edge = RxD_data_ready && !prev;
    assign full      = (count == DEPTH_C);
    // A full FIFO rejects the byte even if a pop happens in the same cycle.
    assign push      = byte_edge && !full;
    assign pop       = (state == IDLE) && (count != '0);
    assign flush     = (state == DECODE) && (cur_byte == 8'h0D);

    always_comb begin
        count_next = count;
        if (flush) begin
            // Flush wins over a same-cycle push: the re-init discards everything queued.
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // prev resets high so a level already asserted at release is not taken as a byte.
            prev     <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            RDY      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            prev  <= RxD_data_ready;
            count <= count_next;
            RDY   <= (count_next != DEPTH_C);
            if (byte_edge && full) begin
                overflow <= 1'b1;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= RxD_data;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= INIT_WAIT;
            act        <= ACT_NONE;
            init_entry <= 1'b1;
            init_req   <= 1'b0;
            cur_byte   <= 8'h00;
            wr_valid   <= 1'b0;
            wr_rs      <= 1'b0;
            wr_data    <= 8'h00;
            cur_row    <= 1'b0;
            cur_col    <= 4'd0;
        end else begin
            init_req <= 1'b0;
            case (state)
                INIT_WAIT: begin
                    // Coming out of reset the request goes out on the first active cycle.
                    if (init_entry) begin
                        init_req <= 1'b1;
                    end
                    init_entry <= 1'b0;
                    if (init_done) begin
                        cur_row <= 1'b0;
                        cur_col <= 4'd0;
                        state   <= IDLE;
                    end
                end

                IDLE: begin
                    if (pop) begin
                        cur_byte <= mem[rd_ptr];
                        state    <= DECODE;
                    end
                end

                DECODE: begin
                    state <= IDLE;
                    if (cur_byte >= 8'h20 && cur_byte <= 8'h7E) begin
                        wr_valid <= 1'b1;
                        wr_rs    <= 1'b1;
                        wr_data  <= cur_byte;
                        act      <= ACT_CHAR;
                        state    <= WAIT_DONE;
                    end else begin
                        case (cur_byte)
                            8'h0C: begin
                                wr_valid <= 1'b1;
                                wr_rs    <= 1'b0;
                                wr_data  <= 8'h01;
                                act      <= ACT_HOME;
                                state    <= WAIT_DONE;
                            end
                            8'h0A: begin
                                wr_valid <= 1'b1;
                                wr_rs    <= 1'b0;
                                wr_data  <= ddram_cmd(!cur_row, 4'd0);
                                act      <= ACT_NEWLINE;
                                state    <= WAIT_DONE;
                            end
                            8'h0D: begin
                                // FIFO flush happens in the datapath on this same cycle.
                                cur_row  <= 1'b0;
                                cur_col  <= 4'd0;
                                init_req <= 1'b1;
                                state    <= INIT_WAIT;
                            end
                            default: begin
                            end
                        endcase
                    end
                end

                ISSUE: begin
                    // Address command after a line wrap; cursor already points at the new line.
                    wr_valid <= 1'b1;
                    wr_rs    <= 1'b0;
                    wr_data  <= ddram_cmd(cur_row, cur_col);
                    act      <= ACT_NONE;
                    state    <= WAIT_DONE;
                end

                WAIT_DONE: begin
                    if (wr_done) begin
                        wr_valid <= 1'b0;
                        state    <= IDLE;
                        case (act)
                            ACT_CHAR: begin
                                if (cur_col == LAST_COL) begin
                                    cur_col <= 4'd0;
                                    cur_row <= !cur_row;
                                    state   <= ISSUE;
                                end else begin
                                    cur_col <= cur_col + 4'd1;
                                end
                            end
                            ACT_HOME: begin
                                cur_row <= 1'b0;
                                cur_col <= 4'd0;
                            end
                            ACT_NEWLINE: begin
                                cur_row <= !cur_row;
                                cur_col <= 4'd0;
                            end
                            default: begin
                            end
                        endcase
                    end
                end

                default: begin
                    state <= INIT_WAIT;
                end
            endcase
        end
    end

endmodule
